mem_arbiter: RTL and testbench

Shares the single-port, 16-bit program/data memory among three requesters: instruction fetch (port F), the load/store path (port L) and the memory-mapped I/O / video port (port V). It does round-robin arbitration with registered grants and drives one memory transaction at a time. It returns read data with a valid pulse to the winning port. It sits between the CPU control FSM / datapath and the memory block and replaces direct CPU drive of the memory address, write-data and write-enable lines.

---
 rtl/mem_arbiter_if.sv | 56 +++++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the three memory requesters (F, L, V), the arbiter and
// the single-port memory. The arbiter takes the slave side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic              v_req;
    logic              v_we;
    logic [ADDR_W-1:0] v_addr;
    logic [DATA_W-1:0] v_wdata;
    logic              v_gnt;
    logic              v_rvalid;
    logic [DATA_W-1:0] v_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  f_req, f_addr,
        input  l_req, l_we, l_addr, l_wdata,
        input  v_req, v_we, v_addr, v_wdata,
        input  mem_rdata,
        output f_gnt, f_rvalid, f_rdata,
        output l_gnt, l_rvalid, l_rdata,
        output v_gnt, v_rvalid, v_rdata,
        output mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output f_req, f_addr,
        output l_req, l_we, l_addr, l_wdata,
        output v_req, v_we, v_addr, v_wdata,
        output mem_rdata,
        input  f_gnt, f_rvalid, f_rdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  v_gnt, v_rvalid, v_rdata,
        input  mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among instruction fetch
// (F), load/store (L) and I/O/video (V); one transaction at a time.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RETURN = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [1:0]        last_r;
    logic              mask_vld_r;
    logic [2:0]        gnt_r, rvalid_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              we_r;
    logic              busy_r;
    logic [DATA_W-1:0] f_hold_r, l_hold_r, v_hold_r;

    logic [2:0]        req_s, elig_s, rot_s;
    logic [1:0]        first_s, win_s;
    logic              win_vld_s, arb_s, win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;

    function automatic logic [2:0] port_onehot(input logic [1:0] p);
        case (p)
            2'd0:    port_onehot = 3'b001;
            2'd1:    port_onehot = 3'b010;
            2'd2:    port_onehot = 3'b100;
            default: port_onehot = 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        case (p)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

    // Winner selection: eligibility is rotated so bit 0 is the port after `last`.
    always_comb begin
        arb_s   = (state_r == IDLE) || (state_r == RETURN);
        req_s   = {bus.v_req, bus.l_req, bus.f_req};
        elig_s  = req_s & ~(mask_vld_r ? port_onehot(last_r) : 3'b000);
        first_s = rr_next(last_r);
        case (last_r)
            2'd0:    rot_s = {elig_s[0], elig_s[2], elig_s[1]};
            2'd1:    rot_s = {elig_s[1], elig_s[0], elig_s[2]};
            default: rot_s = elig_s;
        endcase
        win_vld_s = 1'b1;
        casez (rot_s)
            3'b??1:  win_s = first_s;
            3'b?10:  win_s = rr_next(first_s);
            3'b100:  win_s = rr_next(rr_next(first_s));
            default: begin
                win_vld_s = 1'b0;
                win_s     = first_s;
            end
        endcase
        case (win_s)
            2'd1: begin
                win_addr_s  = bus.l_addr;
                win_we_s    = bus.l_we;
                win_wdata_s = bus.l_wdata;
            end
            2'd2: begin
                win_addr_s  = bus.v_addr;
                win_we_s    = bus.v_we;
                win_wdata_s = bus.v_wdata;
            end
            default: begin
                win_addr_s  = bus.f_addr;
                win_we_s    = 1'b0;
                win_wdata_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Next-state logic; a write finishes in ACCESS, a read goes on to RETURN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = win_vld_s ? ACCESS : IDLE;
            ACCESS:  state_s = we_r ? IDLE : RETURN;
            RETURN:  state_s = win_vld_s ? ACCESS : IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant, memory command and rvalid registers; mask is one arbitration edge long.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r     <= 2'd2;
            mask_vld_r <= 1'b0;
            gnt_r      <= 3'b000;
            rvalid_r   <= 3'b000;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            we_r       <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            gnt_r    <= 3'b000;
            rvalid_r <= 3'b000;
            busy_r   <= (state_s != IDLE);
            if (arb_s && win_vld_s) begin
                addr_r     <= win_addr_s;
                wdata_r    <= win_wdata_s;
                we_r       <= win_we_s;
                gnt_r      <= port_onehot(win_s);
                last_r     <= win_s;
                mask_vld_r <= 1'b1;
            end else if (arb_s) begin
                we_r       <= 1'b0;
                mask_vld_r <= 1'b0;
            end else begin
                we_r     <= 1'b0;
                rvalid_r <= we_r ? 3'b000 : port_onehot(last_r);
            end
        end
    end

    // Read-data hold registers, loaded as the RETURN cycle closes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_hold_r <= {DATA_W{1'b0}};
            l_hold_r <= {DATA_W{1'b0}};
            v_hold_r <= {DATA_W{1'b0}};
        end else if (state_r == RETURN) begin
            case (last_r)
                2'd0:    f_hold_r <= bus.mem_rdata;
                2'd1:    l_hold_r <= bus.mem_rdata;
                2'd2:    v_hold_r <= bus.mem_rdata;
                default: f_hold_r <= f_hold_r;
            endcase
        end else begin
            f_hold_r <= f_hold_r;
        end
    end

    assign bus.f_gnt     = gnt_r[0];
    assign bus.l_gnt     = gnt_r[1];
    assign bus.v_gnt     = gnt_r[2];
    assign bus.f_rvalid  = rvalid_r[0];
    assign bus.l_rvalid  = rvalid_r[1];
    assign bus.v_rvalid  = rvalid_r[2];
    // The memory delivers data during RETURN; outside it the held copy is shown.
    assign bus.f_rdata   = rvalid_r[0] ? bus.mem_rdata : f_hold_r;
    assign bus.l_rdata   = rvalid_r[1] ? bus.mem_rdata : l_hold_r;
    assign bus.v_rdata   = rvalid_r[2] ? bus.mem_rdata : v_hold_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.mem_we    = we_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model and a reference memory copy.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Synchronous memory: read data appears one cycle after the address.
    logic [15:0] mem [0:1023];
    logic        bd_en = 1'b0;
    logic [9:0]  bd_addr = 10'd0;
    logic [15:0] bd_data = 16'd0;
    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        else if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr[9:0]];
    end

    logic [2:0]  rq, wea;
    logic [15:0] ada [3];
    logic [15:0] wda [3];

    logic [15:0] ref_mem [0:1023];
    int          m_last, m_mask, m_wait, m_pend;
    logic [15:0] m_pend_addr;
    logic [2:0]  exp_gnt, exp_rv;
    logic        exp_we, exp_busy;
    logic [15:0] exp_addr, exp_wdata;
    logic [15:0] exp_rd [3];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic model_reset();
        m_last = 2; m_mask = -1; m_wait = 0; m_pend = -1;
        exp_gnt = 3'b000; exp_rv = 3'b000; exp_we = 1'b0; exp_busy = 1'b0;
        exp_addr = 16'd0; exp_wdata = 16'd0;
        for (int p = 0; p < 3; p++) exp_rd[p] = 16'd0;
    endtask

    // One clock edge of the arbiter seen at transaction level.
    task automatic model_edge();
        exp_gnt = 3'b000; exp_rv = 3'b000; exp_we = 1'b0;
        if (m_pend >= 0) begin
            exp_rv[m_pend] = 1'b1;
            exp_rd[m_pend] = ref_mem[m_pend_addr[9:0]];
            m_pend = -1;
        end
        if (m_wait > 0) begin
            m_wait--;
        end else begin
            int w;
            w = -1;
            for (int k = 1; k <= 3; k++) begin
                int p;
                p = (m_last + k) % 3;
                if (w < 0 && rq[p] && p != m_mask) w = p;
            end
            if (w >= 0) begin
                exp_gnt[w] = 1'b1;
                exp_addr   = ada[w];
                exp_we     = (w != 0) && wea[w];
                exp_wdata  = wda[w];
                m_last = w; m_mask = w; m_wait = 1;
                if (exp_we) ref_mem[ada[w][9:0]] = wda[w];
                else begin m_pend = w; m_pend_addr = ada[w]; end
            end else begin
                m_mask = -1;
            end
        end
        exp_busy = (exp_gnt != 3'b000) || (exp_rv != 3'b000);
    endtask

    task automatic drive_bus();
        bus.f_req = rq[0]; bus.f_addr = ada[0];
        bus.l_req = rq[1]; bus.l_we = wea[1]; bus.l_addr = ada[1]; bus.l_wdata = wda[1];
        bus.v_req = rq[2]; bus.v_we = wea[2]; bus.v_addr = ada[2]; bus.v_wdata = wda[2];
    endtask

    // Apply inputs for the next rising edge, advance the model, sample mid-cycle.
    task automatic tick();
        drive_bus();
        model_edge();
        @(negedge clk);
    endtask

    task automatic poke(input logic [9:0] a, input logic [15:0] d);
        bd_en = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
        tick();
        bd_en = 1'b0;
    endtask

    task automatic do_reset();
        rq = 3'b000;
        drive_bus();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    function automatic logic [15:0] rd_of(input int p);
        case (p)
            0:       return bus.f_rdata;
            1:       return bus.l_rdata;
            default: return bus.v_rdata;
        endcase
    endfunction

    task automatic test_reset();
        n_vec++;
        if ({bus.v_gnt, bus.l_gnt, bus.f_gnt, bus.v_rvalid, bus.l_rvalid, bus.f_rvalid} !== 6'd0) begin
            n_err++; $display("FAIL reset_pulses: got %b expected 000000",
                {bus.v_gnt, bus.l_gnt, bus.f_gnt, bus.v_rvalid, bus.l_rvalid, bus.f_rvalid});
        end
        n_vec++;
        if ({bus.busy, bus.mem_we} !== 2'b00) begin
            n_err++; $display("FAIL reset_busy_we: got %b expected 00", {bus.busy, bus.mem_we});
        end
        n_vec++;
        if ({bus.mem_addr, bus.mem_wdata} !== 32'd0) begin
            n_err++; $display("FAIL reset_mem_bus: got %h expected 0", {bus.mem_addr, bus.mem_wdata});
        end
        n_vec++;
        if ({bus.f_rdata, bus.l_rdata, bus.v_rdata} !== 48'd0) begin
            n_err++; $display("FAIL reset_rdata: got %h expected 0", {bus.f_rdata, bus.l_rdata, bus.v_rdata});
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_fetch_read();
        poke(10'h010, 16'h1234);
        ada[0] = 16'h0010; rq[0] = 1'b1;
        tick();
        n_vec++;
        if ({bus.v_gnt, bus.l_gnt, bus.f_gnt, bus.busy, bus.mem_we} !== 5'b00110 || bus.mem_addr !== 16'h0010) begin
            n_err++; $display("FAIL fetch_grant: got gnt=%b busy=%b we=%b addr=%h expected 001 1 0 0010",
                {bus.v_gnt, bus.l_gnt, bus.f_gnt}, bus.busy, bus.mem_we, bus.mem_addr);
        end
        rq[0] = 1'b0;
        tick();
        n_vec++;
        if ({bus.f_rvalid, bus.f_gnt, bus.busy} !== 3'b101 || bus.f_rdata !== 16'h1234) begin
            n_err++; $display("FAIL fetch_data: got rvalid=%b gnt=%b busy=%b rdata=%h expected 1 0 1 1234",
                bus.f_rvalid, bus.f_gnt, bus.busy, bus.f_rdata);
        end
        tick();
        n_vec++;
        if ({bus.f_rvalid, bus.busy} !== 2'b00 || bus.f_rdata !== 16'h1234) begin
            n_err++; $display("FAIL fetch_after: got rvalid=%b busy=%b rdata=%h expected 0 0 1234",
                bus.f_rvalid, bus.busy, bus.f_rdata);
        end
    endtask

    task automatic test_write_read();
        int rv_cnt;
        rv_cnt = 0;
        ada[1] = 16'h0200; wda[1] = 16'hBEEF; wea[1] = 1'b1; rq[1] = 1'b1;
        tick();
        n_vec++;
        if ({bus.v_gnt, bus.l_gnt, bus.f_gnt, bus.mem_we} !== 4'b0101 ||
            bus.mem_addr !== 16'h0200 || bus.mem_wdata !== 16'hBEEF) begin
            n_err++; $display("FAIL write_cycle: got gnt=%b we=%b addr=%h wdata=%h expected 010 1 0200 beef",
                {bus.v_gnt, bus.l_gnt, bus.f_gnt}, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        rq[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            rv_cnt += int'(bus.l_rvalid);
        end
        wea[1] = 1'b0; rq[1] = 1'b1;
        tick();
        rq[1] = 1'b0;
        tick();
        rv_cnt += int'(bus.l_rvalid);
        n_vec++;
        if (bus.l_rvalid !== 1'b1 || bus.l_rdata !== 16'hBEEF) begin
            n_err++; $display("FAIL write_readback: got rvalid=%b rdata=%h expected 1 beef", bus.l_rvalid, bus.l_rdata);
        end
        tick();
        rv_cnt += int'(bus.l_rvalid);
        n_vec++;
        if (rv_cnt != 1) begin
            n_err++; $display("FAIL write_rvalid_count: got %0d expected 1", rv_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] d [3];
        do_reset();
        for (int p = 0; p < 3; p++) begin
            d[p] = 16'($urandom);
            ada[p] = 16'h0100 + 16'(p);
            wea[p] = 1'b0;
            poke(ada[p][9:0], d[p]);
        end
        rq = 3'b111;
        for (int i = 1; i <= 12; i++) begin
            int p;
            tick();
            p = ((i - 1) / 2) % 3;
            n_vec++;
            if (i % 2 == 1) begin
                if ({bus.v_gnt, bus.l_gnt, bus.f_gnt} !== 3'(1 << p) ||
                    {bus.v_rvalid, bus.l_rvalid, bus.f_rvalid} !== 3'b000) begin
                    n_err++; $display("FAIL rr_grant cycle %0d: got gnt=%b rvalid=%b expected gnt=%b", i,
                        {bus.v_gnt, bus.l_gnt, bus.f_gnt}, {bus.v_rvalid, bus.l_rvalid, bus.f_rvalid}, 3'(1 << p));
                end
            end else begin
                if ({bus.v_rvalid, bus.l_rvalid, bus.f_rvalid} !== 3'(1 << p) ||
                    {bus.v_gnt, bus.l_gnt, bus.f_gnt} !== 3'b000 || rd_of(p) !== d[p]) begin
                    n_err++; $display("FAIL rr_return cycle %0d: got rvalid=%b gnt=%b rdata=%h expected rvalid=%b rdata=%h",
                        i, {bus.v_rvalid, bus.l_rvalid, bus.f_rvalid}, {bus.v_gnt, bus.l_gnt, bus.f_gnt},
                        rd_of(p), 3'(1 << p), d[p]);
                end
            end
        end
        rq = 3'b000;
        repeat (3) tick();
    endtask

    task automatic test_mask();
        int first, second, cnt;
        first = -1; second = -1; cnt = 0;
        ada[2] = 16'h0300; wea[2] = 1'b0; rq[2] = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (bus.v_gnt === 1'b1) begin
                cnt++;
                if (first < 0) first = t;
                else if (second < 0) second = t;
            end
            if (first > 0 && t == first + 3) rq[2] = 1'b0;
        end
        rq[2] = 1'b0;
        n_vec++;
        if (cnt != 2 || first < 0 || second != first + 3) begin
            n_err++; $display("FAIL mask_regrant: got %0d grants at %0d,%0d expected 2 grants 3 cycles apart",
                cnt, first, second);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] old;
        old = ref_mem[10'h040];
        ada[1] = 16'h0040; wda[1] = ~old; wea[1] = 1'b1; rq = 3'b010;
        tick();
        n_vec++;
        if (bus.mem_we !== 1'b1 || bus.l_gnt !== 1'b1) begin
            n_err++; $display("FAIL midreset_access: got we=%b gnt=%b expected 1 1", bus.mem_we, bus.l_gnt);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({bus.mem_we, bus.busy, bus.l_gnt, bus.l_rvalid} !== 4'b0000 || bus.mem_addr !== 16'd0) begin
            n_err++; $display("FAIL midreset_async: got we=%b busy=%b gnt=%b rvalid=%b addr=%h expected all 0",
                bus.mem_we, bus.busy, bus.l_gnt, bus.l_rvalid, bus.mem_addr);
        end
        rq = 3'b000;
        drive_bus();
        @(negedge clk);
        n_vec++;
        if ({bus.l_rvalid, bus.busy} !== 2'b00) begin
            n_err++; $display("FAIL midreset_hold: got rvalid=%b busy=%b expected 0 0", bus.l_rvalid, bus.busy);
        end
        reset = 1'b1;
        model_reset();
        ref_mem[10'h040] = old;
        ada[0] = 16'h0041; wea[1] = 1'b0; rq = 3'b011;
        tick();
        n_vec++;
        if ({bus.v_gnt, bus.l_gnt, bus.f_gnt} !== 3'b001) begin
            n_err++; $display("FAIL midreset_first: got gnt=%b expected 001", {bus.v_gnt, bus.l_gnt, bus.f_gnt});
        end
        rq[0] = 1'b0;
        repeat (2) tick();
        rq[1] = 1'b0;
        tick();
        n_vec++;
        if (bus.l_rvalid !== 1'b1 || bus.l_rdata !== old) begin
            n_err++; $display("FAIL midreset_abandon: got rvalid=%b rdata=%h expected 1 %h", bus.l_rvalid, bus.l_rdata, old);
        end
        repeat (2) tick();
    endtask

    task automatic test_v_hold();
        logic [15:0] vd, prev_f;
        vd = 16'($urandom);
        poke(10'h0FF, vd);
        ada[2] = 16'h00FF; wea[2] = 1'b0; rq = 3'b100;
        tick();
        rq[2] = 1'b0;
        tick();
        n_vec++;
        if (bus.v_rvalid !== 1'b1 || bus.v_rdata !== vd) begin
            n_err++; $display("FAIL vhold_read: got rvalid=%b rdata=%h expected 1 %h", bus.v_rvalid, bus.v_rdata, vd);
        end
        prev_f = bus.f_rdata;
        for (int t = 0; t < 15; t++) begin
            if (!rq[0]) begin ada[0] = 16'($urandom_range(0, 63)); rq[0] = 1'b1; end
            tick();
            if (exp_gnt[0]) rq[0] = 1'b0;
            n_vec++;
            if (bus.v_rdata !== vd || (bus.f_rdata !== prev_f && bus.f_rvalid !== 1'b1) ||
                (bus.f_rvalid === 1'b1 && bus.f_rdata !== exp_rd[0])) begin
                n_err++; $display("FAIL vhold_stable t=%0d: got v_rdata=%h f_rdata=%h f_rvalid=%b expected v_rdata=%h f_rdata=%h",
                    t, bus.v_rdata, bus.f_rdata, bus.f_rvalid, vd, exp_rd[0]);
            end
            prev_f = bus.f_rdata;
        end
        rq = 3'b000;
        repeat (3) tick();
    endtask

    task automatic test_random();
        int gap [3];
        int xh [3];
        bit post [3];
        for (int p = 0; p < 3; p++) begin gap[p] = p; xh[p] = 0; post[p] = 1'b0; end
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 3; p++) begin
                if (!rq[p]) begin
                    if (gap[p] == 0) begin
                        rq[p] = 1'b1; post[p] = 1'b0;
                        ada[p] = 16'($urandom_range(0, 63));
                        wea[p] = (p == 0) ? 1'b0 : 1'($urandom);
                        wda[p] = 16'($urandom);
                    end else begin
                        gap[p]--;
                    end
                end
            end
            tick();
            n_vec++;
            if ({bus.v_gnt, bus.l_gnt, bus.f_gnt} !== exp_gnt ||
                {bus.v_rvalid, bus.l_rvalid, bus.f_rvalid} !== exp_rv ||
                bus.busy !== exp_busy || bus.mem_we !== exp_we ||
                (exp_gnt != 3'b000 && bus.mem_addr !== exp_addr) ||
                (exp_we && bus.mem_wdata !== exp_wdata)) begin
                n_err++; $display("FAIL rand_ctrl c=%0d: got gnt=%b rv=%b busy=%b we=%b addr=%h wd=%h expected gnt=%b rv=%b busy=%b we=%b addr=%h wd=%h",
                    c, {bus.v_gnt, bus.l_gnt, bus.f_gnt}, {bus.v_rvalid, bus.l_rvalid, bus.f_rvalid},
                    bus.busy, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                    exp_gnt, exp_rv, exp_busy, exp_we, exp_addr, exp_wdata);
            end
            for (int p = 0; p < 3; p++) begin
                n_vec++;
                if (rd_of(p) !== exp_rd[p]) begin
                    n_err++; $display("FAIL rand_rdata c=%0d port %0d: got %h expected %h", c, p, rd_of(p), exp_rd[p]);
                end
                if (rq[p] && exp_gnt[p]) begin post[p] = 1'b1; xh[p] = $urandom_range(0, 2); end
                if (rq[p] && post[p]) begin
                    if (xh[p] == 0) begin rq[p] = 1'b0; gap[p] = $urandom_range(0, 4); end
                    else xh[p]--;
                end
            end
        end
        rq = 3'b000;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        rq = 3'b000; wea = 3'b000;
        for (int p = 0; p < 3; p++) begin ada[p] = 16'd0; wda[p] = 16'd0; end
        drive_bus();
        model_reset();
        #1 reset = 1'b0;
        bd_en = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            bd_addr = 10'(i);
            bd_data = 16'($urandom);
            ref_mem[i] = bd_data;
            @(negedge clk);
        end
        bd_en = 1'b0;
        test_reset();
        test_fetch_read();
        test_write_read();
        test_round_robin();
        test_mask();
        test_reset_mid();
        test_v_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
